// File: rtl/wtm_reset_sequencer.sv
// wtm_reset_sequencer: reset synchroniser, stretcher and ordered multi-channel releaser.
//
// An external asynchronous active-low reset is synchronised through a SYNC_STAGES-deep
// flop chain, held for STRETCH_CYCLES clocks, and then the CHANNELS reset outputs are
// released one at a time (bit 0 first), STAGE_GAP clocks apart. A synchronous soft_rst
// request re-runs the whole sequence without touching the synchroniser chain.
//
// Optional build macro WTM_RESET_SEQ_CAUSE_EN adds a sticky rst_cause output:
// 2'b01 after a hard (rst_n) reset, 2'b10 after a soft reset.

`timescale 1ns / 1ps

module wtm_reset_sequencer #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned CHANNELS       = 3,
    parameter int unsigned STRETCH_CYCLES = 16,
    parameter int unsigned STAGE_GAP      = 8
) (
    input  logic                clock,
    input  logic                rst_n,
    input  logic                soft_rst,
    output logic [CHANNELS-1:0] rst_out_n,
    output logic                rst_done
`ifdef WTM_RESET_SEQ_CAUSE_EN
    ,
    output logic [1:0]          rst_cause
`endif
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("wtm_reset_sequencer: SYNC_STAGES must be >= 2");
    end
    if (CHANNELS < 1) begin : g_bad_channels
        $error("wtm_reset_sequencer: CHANNELS must be >= 1");
    end
    if (STRETCH_CYCLES < 1) begin : g_bad_stretch
        $error("wtm_reset_sequencer: STRETCH_CYCLES must be >= 1");
    end
    if (STAGE_GAP < 1) begin : g_bad_gap
        $error("wtm_reset_sequencer: STAGE_GAP must be >= 1");
    end

    // Counter sized to hold the larger of the two intervals; it never wraps because
    // both terminal compares are equality on a value below CntMax.
    localparam int unsigned CntMax = (STRETCH_CYCLES > STAGE_GAP) ? STRETCH_CYCLES : STAGE_GAP;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] StretchLast = CntW'(STRETCH_CYCLES - 1);
    localparam logic [CntW-1:0] GapLast     = CntW'(STAGE_GAP - 1);
    localparam logic [CntW-1:0] CntOne      = CntW'(1);

    typedef enum logic [1:0] {
        StHold    = 2'd0,
        StRelease = 2'd1,
        StDone    = 2'd2
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_rst;
    state_e                 state_q;
    logic [CntW-1:0]        cnt_q;
    logic [CHANNELS-1:0]    rel_next;

    // ------------------------------------------------------------------
    // Reset synchroniser: shifts a 1 in after rst_n deasserts
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_rst = sync_q[SYNC_STAGES-1];

    // Next release pattern: thermometer shift that frees the lowest still-held channel
    always_comb begin
        rel_next    = '0;
        rel_next[0] = 1'b1;
        for (int i = 1; i < int'(CHANNELS); i++) begin
            rel_next[i] = rst_out_n[i-1];
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StHold;
            cnt_q     <= '0;
            rst_out_n <= '0;
            rst_done  <= 1'b0;
        end else if (soft_rst) begin
            // Soft reset restarts the sequence from any state; stretch begins once it drops.
            state_q   <= StHold;
            cnt_q     <= '0;
            rst_out_n <= '0;
            rst_done  <= 1'b0;
        end else begin
            unique case (state_q)
                StHold: begin
                    if (sync_rst) begin
                        if (cnt_q == StretchLast) begin
                            cnt_q     <= '0;
                            rst_out_n <= rel_next;
                            if (&rel_next) begin
                                state_q  <= StDone;
                                rst_done <= 1'b1;
                            end else begin
                                state_q <= StRelease;
                            end
                        end else begin
                            cnt_q <= cnt_q + CntOne;
                        end
                    end
                end
                StRelease: begin
                    if (cnt_q == GapLast) begin
                        cnt_q     <= '0;
                        rst_out_n <= rel_next;
                        if (&rel_next) begin
                            state_q  <= StDone;
                            rst_done <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                    end
                end
                StDone: begin
                    cnt_q <= '0;
                end
                default: begin
                    state_q   <= StHold;
                    cnt_q     <= '0;
                    rst_out_n <= '0;
                    rst_done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef WTM_RESET_SEQ_CAUSE_EN
    // Sticky record of the most recent reset source
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rst_cause <= 2'b01;
        end else if (soft_rst) begin
            rst_cause <= 2'b10;
        end
    end
`endif

endmodule

// File: tb/tb_wtm_reset_sequencer.sv
// Self-checking bench for wtm_reset_sequencer: scoreboard of per-edge expected outputs.

`timescale 1ns / 1ps

module tb_wtm_reset_sequencer;

    localparam int SyncStages = 2;
    localparam int Stretch    = 16;
    localparam int Gap        = 8;
    localparam int Chans      = 3;
    localparam int FirstRel   = SyncStages + Stretch;

    typedef struct {
        int         edge_no;
        logic [3:0] exp;
    } exp_t;

    logic       clock = 1'b0;
    logic       rst_n;
    logic       soft_rst;
    logic [2:0] rst_out_n;
    logic       rst_done;
    logic [0:0] rst_out_n1;
    logic       rst_done1;
`ifdef WTM_RESET_SEQ_CAUSE_EN
    logic [1:0] rst_cause;
    logic [1:0] rst_cause1;
`endif

    int   edge_cnt = 0;
    int   base;
    int   tests_run = 0;
    int   tests_failed = 0;
    exp_t sb[$];

    always #5 clock = ~clock;

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    wtm_reset_sequencer #(
        .SYNC_STAGES   (SyncStages),
        .CHANNELS      (Chans),
        .STRETCH_CYCLES(Stretch),
        .STAGE_GAP     (Gap)
    ) u_dut (
        .clock    (clock),
        .rst_n    (rst_n),
        .soft_rst (soft_rst),
        .rst_out_n(rst_out_n),
        .rst_done (rst_done)
`ifdef WTM_RESET_SEQ_CAUSE_EN
        ,
        .rst_cause(rst_cause)
`endif
    );

    wtm_reset_sequencer #(
        .SYNC_STAGES   (SyncStages),
        .CHANNELS      (1),
        .STRETCH_CYCLES(Stretch),
        .STAGE_GAP     (Gap)
    ) u_dut1 (
        .clock    (clock),
        .rst_n    (rst_n),
        .soft_rst (soft_rst),
        .rst_out_n(rst_out_n1),
        .rst_done (rst_done1)
`ifdef WTM_RESET_SEQ_CAUSE_EN
        ,
        .rst_cause(rst_cause1)
`endif
    );

    // Expected {rst_done, rst_out_n} at edge 'rel' when channel 0 releases at edge 'first'
    function automatic logic [3:0] seq_at(int rel, int first);
        logic [2:0] v;
        for (int k = 0; k < Chans; k++) begin
            v[k] = (rel >= first + k * Gap);
        end
        return {&v, v};
    endfunction

    task automatic test_reset();
        exp_t item;
        int   rel;
        rst_n    = 1'b1;
        soft_rst = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({rst_done, rst_out_n} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL async_reset: got %b, expected 0000", {rst_done, rst_out_n});
        end
`ifdef WTM_RESET_SEQ_CAUSE_EN
        tests_run++;
        if (rst_cause !== 2'b01) begin
            tests_failed++;
            $display("FAIL cause_power_on: got %b, expected 01", rst_cause);
        end
`endif
        repeat (3) @(negedge clock);
        tests_run++;
        if ({rst_done, rst_out_n, rst_done1, rst_out_n1} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_held: got %b, expected 000000",
                     {rst_done, rst_out_n, rst_done1, rst_out_n1});
        end
        rst_n = 1'b1;
        base  = edge_cnt;
        for (int r = 1; r <= 40; r++) sb.push_back('{r, seq_at(r, FirstRel)});
        for (int r = 1; r <= 40; r++) begin
            @(negedge clock);
            rel  = edge_cnt - base;
            item = sb.pop_front();
            tests_run++;
            if (rel != item.edge_no || {rst_done, rst_out_n} !== item.exp) begin
                tests_failed++;
                $display("FAIL power_on_seq edge %0d: got %b, expected %b at edge %0d",
                         rel, {rst_done, rst_out_n}, item.exp, item.edge_no);
            end
            if (r == FirstRel - 1 || r == FirstRel) begin
                tests_run++;
                if ({rst_done1, rst_out_n1} !== ((r == FirstRel) ? 2'b11 : 2'b00)) begin
                    tests_failed++;
                    $display("FAIL single_channel edge %0d: got %b, expected %b", rel,
                             {rst_done1, rst_out_n1}, (r == FirstRel) ? 2'b11 : 2'b00);
                end
            end
        end
    endtask

    task automatic test_soft_in_done();
        exp_t item;
        int   rel;
        for (int r = 41; r <= 90; r++) begin
            sb.push_back('{r, (r < 50) ? seq_at(r, FirstRel) : seq_at(r, 50 + Stretch)});
        end
        for (int r = 41; r <= 90; r++) begin
            @(negedge clock);
            rel  = edge_cnt - base;
            item = sb.pop_front();
            tests_run++;
            if (rel != item.edge_no || {rst_done, rst_out_n} !== item.exp) begin
                tests_failed++;
                $display("FAIL soft_in_done edge %0d: got %b, expected %b at edge %0d",
                         rel, {rst_done, rst_out_n}, item.exp, item.edge_no);
            end
            if (r == 49) soft_rst = 1'b1;
            if (r == 50) soft_rst = 1'b0;
        end
`ifdef WTM_RESET_SEQ_CAUSE_EN
        tests_run++;
        if (rst_cause !== 2'b10) begin
            tests_failed++;
            $display("FAIL cause_soft: got %b, expected 10", rst_cause);
        end
`endif
    endtask

    task automatic test_async_abort();
        exp_t item;
        int   rel;
        @(posedge clock);
        #1 rst_n = 1'b0;
        #2;
        tests_run++;
        if ({rst_done, rst_out_n} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL async_abort: got %b, expected 0000", {rst_done, rst_out_n});
        end
`ifdef WTM_RESET_SEQ_CAUSE_EN
        tests_run++;
        if (rst_cause !== 2'b01) begin
            tests_failed++;
            $display("FAIL cause_hard: got %b, expected 01", rst_cause);
        end
`endif
        #3 rst_n = 1'b1;
        base = edge_cnt;
        for (int r = 1; r <= 40; r++) sb.push_back('{r, seq_at(r, FirstRel)});
        for (int r = 1; r <= 40; r++) begin
            @(negedge clock);
            rel  = edge_cnt - base;
            item = sb.pop_front();
            tests_run++;
            if (rel != item.edge_no || {rst_done, rst_out_n} !== item.exp) begin
                tests_failed++;
                $display("FAIL rerun_seq edge %0d: got %b, expected %b at edge %0d",
                         rel, {rst_done, rst_out_n}, item.exp, item.edge_no);
            end
        end
    endtask

    task automatic test_soft_in_release();
        exp_t item;
        int   rel;
        @(posedge clock);
        #1 rst_n = 1'b0;
        #5 rst_n = 1'b1;
        base = edge_cnt;
        for (int r = 1; r <= 64; r++) begin
            sb.push_back('{r, (r < 30) ? seq_at(r, FirstRel) : seq_at(r, 30 + Stretch)});
        end
        for (int r = 1; r <= 64; r++) begin
            @(negedge clock);
            rel  = edge_cnt - base;
            item = sb.pop_front();
            tests_run++;
            if (rel != item.edge_no || {rst_done, rst_out_n} !== item.exp) begin
                tests_failed++;
                $display("FAIL soft_in_release edge %0d: got %b, expected %b at edge %0d",
                         rel, {rst_done, rst_out_n}, item.exp, item.edge_no);
            end
            if (r == 29) soft_rst = 1'b1;
            if (r == 30) soft_rst = 1'b0;
        end
    endtask

    task automatic test_soft_held();
        exp_t item;
        int   rel;
        @(posedge clock);
        #1 rst_n = 1'b0;
        #5 rst_n = 1'b1;
        base = edge_cnt;
        for (int r = 1; r <= 80; r++) begin
            sb.push_back('{r, (r < 40) ? seq_at(r, FirstRel) : seq_at(r, 44 + Stretch)});
        end
        for (int r = 1; r <= 80; r++) begin
            @(negedge clock);
            rel  = edge_cnt - base;
            item = sb.pop_front();
            tests_run++;
            if (rel != item.edge_no || {rst_done, rst_out_n} !== item.exp) begin
                tests_failed++;
                $display("FAIL soft_held edge %0d: got %b, expected %b at edge %0d",
                         rel, {rst_done, rst_out_n}, item.exp, item.edge_no);
            end
            if (r == 39) soft_rst = 1'b1;
            if (r == 44) soft_rst = 1'b0;
        end
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_soft_in_done();
        test_async_abort();
        test_soft_in_release();
        test_soft_held();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/wtm_reset_sequencer.md
Name: wtm_reset_sequencer

Overview:
- Parametrised successor to the two-flop reset synchroniser.
- Synchronises an external asynchronous active-low reset into the clock domain with configurable synchroniser depth.
- Stretches the reset to a minimum length, then releases several reset channels in a fixed order with a programmable gap between them (e.g. bus fabric, then CPU glue, then peripherals).
- Also accepts a synchronous soft-reset request that re-runs the full sequence. Sits at the top of the FPGA design, feeding every clock-domain-local reset.

Parameters:
- SYNC_STAGES, 2, synchroniser flip-flop count; must be >= 2.
- CHANNELS, 3, number of reset outputs; must be >= 1.
- STRETCH_CYCLES, 16, clocks held in reset after the synchronised reset releases; must be >= 1.
- STAGE_GAP, 8, clocks between successive channel releases; must be >= 1.

Ports:
- clock  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  external reset; asynchronous, active-low.
- soft_rst  in  1  synchronous soft-reset request, active-high, driven from the clock domain.
- rst_out_n  out  CHANNELS  per-channel reset, active-low, registered; bit 0 releases first.
- rst_done  out  1  high once every channel is released.

Behaviour:
- Reset scheme (already decided): one clock; reset is asynchronous and active-low.
- rst_n low, asynchronously and with no clock required:
  - synchroniser chain and all state cleared;
  - rst_out_n = all 0, rst_done = 0, FSM = HOLD, counter = 0.
- rst_n release:
  - a 1 shifts through the SYNC_STAGES chain;
  - the synchronised reset goes high after the SYNC_STAGES-th rising edge following release.
- All outputs come directly from flops. There are no combinational paths from inputs to outputs, so there are no glitches.
- FSM states:
  - HOLD: all channels low. At each edge where the synchronised reset is high and soft_rst is low, the counter increments. On the STRETCH_CYCLES-th such edge: rst_out_n[0] <= 1, counter <= 0, go to RELEASE (or DONE if CHANNELS = 1).
  - RELEASE: the counter counts edges. Every STAGE_GAP edges the next channel is released (rst_out_n[k] <= 1) and the counter resets. Releasing channel CHANNELS-1 goes to DONE and sets rst_done <= 1 on the same edge.
  - DONE: outputs stable, all 1; rst_done = 1.
- soft_rst sampled high at edge N, in any state:
  - after edge N: rst_out_n = all 0, rst_done = 0, counter = 0, FSM = HOLD;
  - the synchroniser chain is not affected.
- soft_rst held high for several cycles: the FSM stays in HOLD with counter 0. Counting starts at the first edge with soft_rst low.
- Resulting latency:
  - channel 0 releases after edge SYNC_STAGES + STRETCH_CYCLES counted from the first edge after rst_n release;
  - or after edge N + STRETCH_CYCLES, where N is the last edge with soft_rst high;
  - channel k releases k*STAGE_GAP edges after channel 0.
- rst_n asserted mid-sequence (HOLD, RELEASE or DONE) aborts immediately and asynchronously. The full sequence re-runs on release.
- The counter is $clog2(max(STRETCH_CYCLES, STAGE_GAP)+1) bits wide and never wraps; the terminal compare is equality.
- Parameter violations are flagged with a generate-time error.

Optional Feature:
- Macro WTM_RESET_SEQ_CAUSE_EN.
- Defined:
  - adds output port rst_cause, 2 bits, registered, sticky;
  - async reset value 2'b01 (hard reset);
  - set to 2'b10 on the edge where soft_rst is sampled high;
  - holds otherwise.
- Undefined: the port and its register are absent. Sequencing behaviour is identical in both builds.

Test Plan:
- Default parameters; rst_n low, then released before edge 1 -> rst_out_n = 3'b000 through edge 17; 3'b001 after edge 18; 3'b011 after edge 26; 3'b111 and rst_done = 1 after edge 34.
- In DONE, soft_rst high for one cycle at edge 50 -> 3'b000 and rst_done = 0 after edge 50; 3'b001 after edge 66; 3'b111 and rst_done = 1 after edge 82.
- soft_rst sampled high at edge 30 (during RELEASE, outputs 3'b011) -> 3'b000 after edge 30; 3'b001 after edge 46; no channel released early.
- rst_n low pulse of 5 ns between edges while in DONE -> rst_out_n = 3'b000 before the next edge; sequence re-runs with the same timing as the first scenario, relative to release.
- soft_rst held high on edges 40–44 -> outputs stay 3'b000; 3'b001 after edge 60.
- With WTM_RESET_SEQ_CAUSE_EN: rst_cause = 2'b01 after power-on; 2'b10 after soft_rst; 2'b01 after a new rst_n pulse. CHANNELS = 1 build: rst_done rises on the same edge as rst_out_n[0].
